// File: rtl/param_service_unit_if.sv
// Bus bundle for param_service_unit: APB slave signals plus the
// event-source and core interrupt handshake signals.
interface param_service_unit_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_LINES       = 32,
  parameter int ID_W           = 5
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;
  logic [NB_LINES-1:0]       signal_i;
  logic                      irq_req_o;
  logic [ID_W-1:0]           irq_id_o;
  logic                      irq_ack_i;
  logic [ID_W-1:0]           irq_ack_id_i;

  // Service unit side.
  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  signal_i, irq_ack_i, irq_ack_id_i,
    output PRDATA, PREADY, PSLVERR,
    output irq_req_o, irq_id_o
  );

  // Bus master / core / event source side.
  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output signal_i, irq_ack_i, irq_ack_id_i,
    input  PRDATA, PREADY, PSLVERR,
    input  irq_req_o, irq_id_o
  );
endinterface

// File: rtl/param_service_unit.sv
// Parametrised APB interrupt/event service unit.
// Collects NB_LINES sources (per-line enable, level/rising-edge mode,
// software set/clear) and offers the lowest-index pending line to the
// core through a registered req/ID handshake with ID-checked acknowledge.
module param_service_unit #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_LINES       = 32,
  parameter int ID_W           = 5
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  param_service_unit_if.slave     bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Lowest set index of a vector; zero when the vector is empty.
  function automatic logic [ID_W-1:0] f_lowest(input logic [NB_LINES-1:0] v);
    logic [ID_W-1:0] res;
    res = {ID_W{1'b0}};
    for (int i = NB_LINES - 1; i >= 0; i--) begin
      if (v[i]) begin
        res = ID_W'(i);
      end
    end
    return res;
  endfunction

  // Registers
  logic [NB_LINES-1:0] r_enable;
  logic [NB_LINES-1:0] r_mode;
  logic [NB_LINES-1:0] r_pending;
  logic [NB_LINES-1:0] r_sig_q;
  state_t              r_state;
  logic                r_irq_req;
  logic [ID_W-1:0]     r_irq_id;

  // APB decode
  logic                w_access;
  logic                w_wr;
  logic                w_rd;
  logic [2:0]          w_off;
  logic [NB_LINES-1:0] w_wdata;
  logic                w_wr_enable;
  logic                w_wr_pending;
  logic                w_wr_set;
  logic                w_wr_clear;
  logic                w_wr_mode;
  logic [31:0]         w_status;
  logic [31:0]         w_prdata;

  // Pending / handshake datapath
  logic [NB_LINES-1:0] w_trig;
  logic [NB_LINES-1:0] w_set;
  logic [NB_LINES-1:0] w_clr;
  logic [NB_LINES-1:0] w_id_onehot;
  logic [NB_LINES-1:0] w_ack_mask;
  logic [NB_LINES-1:0] w_pending_nxt;
  logic                w_ack_valid;
  logic                w_cur_pend;

  // FSM next values
  state_t              w_state_nxt;
  logic                w_req_nxt;
  logic [ID_W-1:0]     w_id_nxt;

  // Only PADDR[4:2] is decoded and PWDATA above NB_LINES is dropped.
  logic w_unused;
  assign w_unused = ^{bus.PADDR, bus.PWDATA};

  assign w_access     = bus.PSEL && bus.PENABLE;
  assign w_wr         = w_access && bus.PWRITE;
  assign w_rd         = w_access && !bus.PWRITE;
  assign w_off        = bus.PADDR[4:2];
  assign w_wdata      = bus.PWDATA[NB_LINES-1:0];
  assign w_wr_enable  = w_wr && (w_off == 3'd0);
  assign w_wr_pending = w_wr && (w_off == 3'd1);
  assign w_wr_set     = w_wr && (w_off == 3'd2);
  assign w_wr_clear   = w_wr && (w_off == 3'd3);
  assign w_wr_mode    = w_wr && (w_off == 3'd4);

  assign bus.PREADY    = 1'b1;
  assign bus.PSLVERR   = w_access && (w_off >= 3'd6);
  assign bus.PRDATA    = w_prdata;
  assign bus.irq_req_o = r_irq_req;
  assign bus.irq_id_o  = r_irq_id;

  // Assemble the STATUS word from the registered handshake outputs.
  always_comb begin
    w_status           = 32'd0;
    w_status[31]       = r_irq_req;
    w_status[ID_W-1:0] = r_irq_id;
  end

  // Read mux; drives zero outside read accesses and for write-only/unmapped offsets.
  always_comb begin
    w_prdata = 32'd0;
    if (w_rd) begin
      case (w_off)
        3'd0:    w_prdata = 32'(r_enable);
        3'd1:    w_prdata = 32'(r_pending);
        3'd4:    w_prdata = 32'(r_mode);
        3'd5:    w_prdata = w_status;
        default: w_prdata = 32'd0;
      endcase
    end else begin
      w_prdata = 32'd0;
    end
  end

  // One-hot of the currently presented ID, used for ack clear and withdraw test.
  always_comb begin
    w_id_onehot = {NB_LINES{1'b0}};
    for (int i = 0; i < NB_LINES; i++) begin
      w_id_onehot[i] = (r_irq_id == ID_W'(i));
    end
  end

  assign w_ack_valid = bus.irq_ack_i && (r_state == S_REQ) &&
                       (bus.irq_ack_id_i == r_irq_id);

  // Next pending: set sources, then clears (clear beats trigger), then a PENDING write overrides.
  always_comb begin
    w_trig     = r_enable & ((r_mode & bus.signal_i & ~r_sig_q) |
                             (~r_mode & bus.signal_i));
    w_set      = w_wr_set   ? w_wdata : {NB_LINES{1'b0}};
    w_clr      = w_wr_clear ? w_wdata : {NB_LINES{1'b0}};
    w_ack_mask = w_ack_valid ? w_id_onehot : {NB_LINES{1'b0}};
    if (w_wr_pending) begin
      w_pending_nxt = w_wdata;
    end else begin
      w_pending_nxt = (r_pending | w_trig | w_set) & ~(w_clr | w_ack_mask);
    end
  end

  // Whether the line being requested is still pending after this edge.
  assign w_cur_pend = |(w_pending_nxt & w_id_onehot);

  // Configuration, pending and edge-detect history registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_enable  <= {NB_LINES{1'b0}};
      r_mode    <= {NB_LINES{1'b0}};
      r_pending <= {NB_LINES{1'b0}};
      r_sig_q   <= {NB_LINES{1'b0}};
    end else begin
      r_sig_q   <= bus.signal_i;
      r_pending <= w_pending_nxt;
      if (w_wr_enable) begin
        r_enable <= w_wdata;
      end
      if (w_wr_mode) begin
        r_mode <= w_wdata;
      end
    end
  end

  // FSM state register together with the registered request outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_irq_req <= 1'b0;
      r_irq_id  <= {ID_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_irq_req <= w_req_nxt;
      r_irq_id  <= w_id_nxt;
    end
  end

  // FSM next state: request when anything is pending, drop on valid ack or software removal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_ack_valid || !w_cur_pend) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: latch the winning ID only when leaving IDLE; hold it otherwise.
  always_comb begin
    w_req_nxt = (w_state_nxt == S_REQ);
    w_id_nxt  = r_irq_id;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_id_nxt = f_lowest(r_pending);
        end else begin
          w_id_nxt = r_irq_id;
        end
      end
      S_REQ:   w_id_nxt = r_irq_id;
      default: w_id_nxt = r_irq_id;
    endcase
  end

endmodule

// File: tb/tb_param_service_unit.sv
// Self-checking bench for param_service_unit: reference-model checked
// directed and random traffic on a 32-line instance, plus a vector table
// run against an 8-line instance.
module tb_param_service_unit;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  param_service_unit_if #(.APB_ADDR_WIDTH(12), .NB_LINES(32), .ID_W(5)) bus  ();
  param_service_unit_if #(.APB_ADDR_WIDTH(12), .NB_LINES(8),  .ID_W(3)) bus8 ();

  param_service_unit #(.APB_ADDR_WIDTH(12), .NB_LINES(32), .ID_W(5)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );
  param_service_unit #(.APB_ADDR_WIDTH(12), .NB_LINES(8), .ID_W(3)) dut8 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model state (behavioural view of the unit)
  logic [31:0] m_en, m_pend, m_mode, m_prev;
  logic        m_req;
  logic [4:0]  m_id;
  logic [31:0] last_rdata;

  task automatic m_reset();
    m_en = 32'd0; m_pend = 32'd0; m_mode = 32'd0; m_prev = 32'd0;
    m_req = 1'b0; m_id = 5'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0:    return m_en;
      3'd1:    return m_pend;
      3'd4:    return m_mode;
      3'd5:    return {m_req, 26'd0, m_id};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the 32-line DUT: inputs already driven by caller at posedge+1.
  task automatic cycle(input string tag);
    logic        acc, wr, vack, nreq;
    logic [2:0]  off;
    logic [31:0] wd, sig, npend, nen, nmode, exp_rd;
    logic [4:0]  nid;
    #1;
    acc  = bus.PSEL && bus.PENABLE;
    wr   = acc && bus.PWRITE;
    off  = bus.PADDR[4:2];
    wd   = bus.PWDATA;
    sig  = bus.signal_i;
    exp_rd = (acc && !bus.PWRITE) ? m_read(off) : 32'd0;
    last_rdata = bus.PRDATA;
    check({tag, "/prdata"}, bus.PRDATA, exp_rd);
    check({tag, "/pslverr"}, 32'(bus.PSLVERR), 32'(acc && (off >= 3'd6)));
    vack = bus.irq_ack_i && m_req && (bus.irq_ack_id_i == m_id);
    for (int i = 0; i < 32; i++) begin
      logic fire, p;
      fire = m_en[i] && (m_mode[i] ? (sig[i] && !m_prev[i]) : sig[i]);
      p = m_pend[i] || fire || (wr && off == 3'd2 && wd[i]);
      if ((wr && off == 3'd3 && wd[i]) || (vack && m_id == 5'(i))) p = 1'b0;
      if (wr && off == 3'd1) p = wd[i];
      npend[i] = p;
    end
    nen   = (wr && off == 3'd0) ? wd : m_en;
    nmode = (wr && off == 3'd4) ? wd : m_mode;
    nreq  = m_req;
    nid   = m_id;
    if (!m_req) begin
      if (m_pend != 32'd0) begin
        nreq = 1'b1;
        for (int i = 31; i >= 0; i--) if (m_pend[i]) nid = 5'(i);
      end
    end else if (vack || !npend[m_id]) begin
      nreq = 1'b0;
    end
    @(posedge HCLK);
    #1;
    m_pend = npend; m_en = nen; m_mode = nmode; m_prev = sig;
    m_req = nreq; m_id = nid;
    check({tag, "/irq_req"}, 32'(bus.irq_req_o), 32'(m_req));
    check({tag, "/irq_id"},  32'(bus.irq_id_o),  32'(m_id));
  endtask

  task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
    cycle(w ? "apb_wr" : "apb_rd");
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle("idle");
  endtask

  task automatic ack(input logic [4:0] id);
    bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = id;
    cycle("ack");
    bus.irq_ack_i = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   rises;
    int   highs;
    logic prev_req;
    vec_t tbl[14];

    // Reset with all sources high and nothing enabled
    HRESET = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 12'd0; bus.PWDATA = 32'd0;
    bus.signal_i = 32'hFFFF_FFFF; bus.irq_ack_i = 1'b0; bus.irq_ack_id_i = 5'd0;
    bus8.PSEL = 1'b0; bus8.PENABLE = 1'b0; bus8.PWRITE = 1'b0; bus8.PADDR = 12'd0; bus8.PWDATA = 32'd0;
    bus8.signal_i = 8'd0; bus8.irq_ack_i = 1'b0; bus8.irq_ack_id_i = 3'd0;
    m_reset();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst/irq_req", 32'(bus.irq_req_o), 32'd0);
    check("rst/irq_id",  32'(bus.irq_id_o),  32'd0);
    check("rst/pready",  32'(bus.PREADY),    32'd1);
    HRESET = 1'b0;
    apb(1'b0, 12'h000, 32'd0); check("rst/enable",  last_rdata, 32'd0);
    apb(1'b0, 12'h004, 32'd0); check("rst/pending", last_rdata, 32'd0);
    apb(1'b0, 12'h010, 32'd0); check("rst/mode",    last_rdata, 32'd0);
    apb(1'b0, 12'h014, 32'd0); check("rst/status",  last_rdata, 32'd0);
    idle(10);
    check("rst/req_stays_low", 32'(bus.irq_req_o), 32'd0);
    bus.signal_i = 32'd0;
    idle(1);

    // Level mode: line 3 held, line 0 pulsed
    apb(1'b1, 12'h000, 32'h9);
    bus.signal_i = 32'h9;
    idle(1);
    bus.signal_i = 32'h8;
    apb(1'b0, 12'h004, 32'd0); check("lvl/pending_09", last_rdata, 32'h9);
    check("lvl/req_id0", {31'd0, bus.irq_req_o} | (32'(bus.irq_id_o) << 8), 32'h1);
    ack(5'd0);
    check("lvl/req_gap", 32'(bus.irq_req_o), 32'd0);
    apb(1'b0, 12'h004, 32'd0); check("lvl/pending_08", last_rdata, 32'h8);
    check("lvl/req_id3", {31'd0, bus.irq_req_o} | (32'(bus.irq_id_o) << 8), 32'h301);
    ack(5'd3);
    check("lvl/req_low_after_ack3", 32'(bus.irq_req_o), 32'd0);
    idle(1);
    apb(1'b0, 12'h004, 32'd0); check("lvl/repend_3", last_rdata, 32'h8);
    bus.signal_i = 32'd0;
    apb(1'b1, 12'h000, 32'd0);
    apb(1'b1, 12'h00C, 32'hFFFF_FFFF);
    idle(2);
    check("lvl/cleanup", 32'(bus.irq_req_o), 32'd0);

    // Edge mode: held-high source gives exactly one request
    apb(1'b1, 12'h010, 32'h4);
    apb(1'b1, 12'h000, 32'h4);
    bus.signal_i = 32'h4;
    rises = 0;
    prev_req = bus.irq_req_o;
    for (int k = 0; k < 10; k++) begin
      cycle("edge_hold");
      if (bus.irq_req_o && !prev_req) rises++;
      prev_req = bus.irq_req_o;
    end
    check("edge/one_request", 32'(rises), 32'd1);
    check("edge/id2", 32'(bus.irq_id_o), 32'd2);
    ack(5'd2);
    highs = 0;
    for (int k = 0; k < 5; k++) begin
      cycle("edge_after_ack");
      if (bus.irq_req_o) highs++;
    end
    check("edge/no_rerequest", 32'(highs), 32'd0);
    bus.signal_i = 32'd0;
    idle(1);
    bus.signal_i = 32'h4;
    idle(2);
    check("edge/new_edge_req", {31'd0, bus.irq_req_o} | (32'(bus.irq_id_o) << 8), 32'h201);
    ack(5'd2);
    bus.signal_i = 32'd0;
    apb(1'b1, 12'h000, 32'd0);
    apb(1'b1, 12'h010, 32'd0);
    idle(1);

    // Software set/clear and wrong-ID ack
    apb(1'b1, 12'h008, 32'h20);
    idle(1);
    check("sw/req_id5", {31'd0, bus.irq_req_o} | (32'(bus.irq_id_o) << 8), 32'h501);
    ack(5'd1);
    check("sw/wrong_ack_ignored", 32'(bus.irq_req_o), 32'd1);
    apb(1'b0, 12'h004, 32'd0); check("sw/pending_kept", last_rdata, 32'h20);
    apb(1'b1, 12'h00C, 32'h20);
    check("sw/clear_withdraws", 32'(bus.irq_req_o), 32'd0);
    apb(1'b0, 12'h004, 32'd0); check("sw/pending_cleared", last_rdata, 32'd0);

    // Same-cycle ack vs edge trigger, PENDING write vs trigger
    apb(1'b1, 12'h000, 32'h10);
    apb(1'b1, 12'h010, 32'h10);
    apb(1'b1, 12'h008, 32'h10);
    idle(1);
    check("sim/req_id4", {31'd0, bus.irq_req_o} | (32'(bus.irq_id_o) << 8), 32'h401);
    bus.signal_i = 32'h10;
    ack(5'd4);
    apb(1'b0, 12'h004, 32'd0); check("sim/ack_beats_trig", last_rdata, 32'd0);
    bus.signal_i = 32'd0;
    apb(1'b1, 12'h010, 32'd0);
    apb(1'b1, 12'h000, 32'h1);
    bus.signal_i = 32'h1;
    apb(1'b1, 12'h004, 32'hF0);
    bus.signal_i = 32'd0;
    apb(1'b0, 12'h004, 32'd0); check("sim/pending_write_wins", last_rdata, 32'hF0);
    apb(1'b1, 12'h000, 32'd0);
    apb(1'b1, 12'h00C, 32'hFFFF_FFFF);
    idle(2);

    // Reset in the middle of a request
    apb(1'b1, 12'h008, 32'h80);
    idle(1);
    check("rstmid/req_up", 32'(bus.irq_req_o), 32'd1);
    HRESET = 1'b1;
    #2;
    check("rstmid/async_drop", 32'(bus.irq_req_o), 32'd0);
    m_reset();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    apb(1'b0, 12'h004, 32'd0); check("rstmid/pending_lost", last_rdata, 32'd0);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) bus.signal_i = $urandom;
      if (bus.irq_req_o && ($urandom_range(0, 2) == 0)) begin
        bus.irq_ack_i = 1'b1;
        bus.irq_ack_id_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : bus.irq_id_o;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1;
        bus.PWRITE = 1'($urandom);
        bus.PADDR = {7'($urandom), 3'($urandom_range(0, 7)), 2'b00};
        bus.PWDATA = $urandom & $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        bus.PWRITE = 1'b1; bus.PADDR = 12'h004; bus.PWDATA = $urandom;
      end
      cycle("rand");
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.irq_ack_i = 1'b0;
    end

    // 8-line instance: register width masking and error decode
    tbl[0]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'd0,          1'b0};
    tbl[1]  = '{1'b0, 12'h000, 32'd0,         32'h0000_00FF,  1'b0};
    tbl[2]  = '{1'b0, 12'h01C, 32'd0,         32'd0,          1'b1};
    tbl[3]  = '{1'b1, 12'h010, 32'h0000_A5A5, 32'd0,          1'b0};
    tbl[4]  = '{1'b0, 12'h010, 32'd0,         32'h0000_00A5,  1'b0};
    tbl[5]  = '{1'b1, 12'h018, 32'hFFFF_FFFF, 32'd0,          1'b1};
    tbl[6]  = '{1'b1, 12'h004, 32'h0000_01FE, 32'd0,          1'b0};
    tbl[7]  = '{1'b0, 12'h004, 32'd0,         32'h0000_00FE,  1'b0};
    tbl[8]  = '{1'b0, 12'h014, 32'd0,         32'h8000_0001,  1'b0};
    tbl[9]  = '{1'b1, 12'h00C, 32'h0000_00FF, 32'd0,          1'b0};
    tbl[10] = '{1'b0, 12'h004, 32'd0,         32'd0,          1'b0};
    tbl[11] = '{1'b0, 12'h014, 32'd0,         32'h0000_0001,  1'b0};
    tbl[12] = '{1'b0, 12'h008, 32'd0,         32'd0,          1'b0};
    tbl[13] = '{1'b0, 12'h00C, 32'd0,         32'd0,          1'b0};
    for (int k = 0; k < 14; k++) begin
      bus8.PSEL = 1'b1; bus8.PENABLE = 1'b1;
      bus8.PWRITE = tbl[k].wr; bus8.PADDR = tbl[k].addr; bus8.PWDATA = tbl[k].wdata;
      #2;
      check($sformatf("nb8/vec%0d/prdata", k), bus8.PRDATA, tbl[k].exp_rdata);
      check($sformatf("nb8/vec%0d/pslverr", k), 32'(bus8.PSLVERR), 32'(tbl[k].exp_err));
      @(posedge HCLK);
      #1;
      bus8.PSEL = 1'b0; bus8.PENABLE = 1'b0; bus8.PWRITE = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
